// File: rtl/dual_rail_shift_pipe_pkg.sv
// Shared types and helpers for the dual-rail CORDIC datapath.
//   dual_rail_t  : one dual-rail bit, [1] = data_1 rail, [0] = data_0 rail
//   shift_mode_t : SH_LSL / SH_LSR / SH_ASR
//   in_state_t   : four-phase input acceptor states
//   dr_complete / dr_null / dr_illegal : per-bit codeword classification
package pa_AsyncCordic;

  localparam int unsigned RW = 7;

  typedef logic [1:0] dual_rail_t;

  localparam dual_rail_t DR_NULL = 2'b00;
  localparam dual_rail_t DR_ZERO = 2'b01;
  localparam dual_rail_t DR_ONE  = 2'b10;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2
  } shift_mode_t;

  typedef enum logic {
    IN_WAIT_DATA = 1'b0,
    IN_WAIT_NULL = 1'b1
  } in_state_t;

  function automatic logic dr_complete(input dual_rail_t b);
    return b[1] ^ b[0];
  endfunction

  function automatic logic dr_null(input dual_rail_t b);
    return b == DR_NULL;
  endfunction

  function automatic logic dr_illegal(input dual_rail_t b);
    return &b;
  endfunction

endpackage

// File: rtl/dual_rail_shift_pipe_if.sv
// Bus bundle for dual_rail_shift_pipe.
//   in_data/in_shamt/in_mode : four-phase dual-rail operand side, in_ack acknowledge
//   out_data/out_valid/out_ready : valid/ready result side
// master = producer/consumer environment, slave = the shifter.
interface dual_rail_shift_pipe_if #(
  parameter int unsigned SIZE    = pa_AsyncCordic::RW,
  parameter int unsigned SHIFT_W = 4
);
  import pa_AsyncCordic::*;

  dual_rail_t [SIZE:0]  in_data;
  logic [SHIFT_W-1:0]   in_shamt;
  shift_mode_t          in_mode;
  logic                 in_ack;
  dual_rail_t [SIZE:0]  out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_shamt, in_mode, out_ready,
    input  in_ack, out_data, out_valid
  );

  modport slave (
    input  in_data, in_shamt, in_mode, out_ready,
    output in_ack, out_data, out_valid
  );

endinterface

// File: rtl/dual_rail_shift_level.sv
// One combinational barrel level: shifts a dual-rail word by the fixed amount
// SHIFT when en is high, otherwise passes it through.
//   din/dout : dual-rail word
//   en       : apply this level's shift
//   mode     : SH_LSL shifts toward MSB, SH_LSR/SH_ASR toward LSB
//   fill     : codeword placed into vacated positions
module dual_rail_shift_level
  import pa_AsyncCordic::*;
#(
  parameter int unsigned SIZE  = RW,
  parameter int unsigned SHIFT = 1
) (
  input  dual_rail_t [SIZE:0] din,
  input  logic                en,
  input  shift_mode_t         mode,
  input  dual_rail_t          fill,
  output dual_rail_t [SIZE:0] dout
);

  for (genvar i = 0; i <= SIZE; i++) begin : g_bit
    dual_rail_t from_lo;
    dual_rail_t from_hi;

    if (i >= SHIFT) begin : g_lo
      assign from_lo = din[i - SHIFT];
    end else begin : g_lo_fill
      assign from_lo = fill;
    end

    if (i + SHIFT <= SIZE) begin : g_hi
      assign from_hi = din[i + SHIFT];
    end else begin : g_hi_fill
      assign from_hi = fill;
    end

    assign dout[i] = !en ? din[i] : (mode == SH_LSL) ? from_lo : from_hi;
  end

endmodule

// File: rtl/dual_rail_shift_pipe.sv
// Pipelined barrel shifter for dual-rail operands. A four-phase (data/NULL)
// acceptor loads stage 0; SHIFT_W binary levels are spread evenly over
// PIPE_STAGES registered stages; the last stage drives a valid/ready output.
//   clk, arst   : clock, synchronous active-high reset
//   bus (slave) : in_data/in_shamt/in_mode/in_ack, out_data/out_valid/out_ready
//   err_illegal : sticky flag for a both-rails-high bit seen while waiting for data
// Optional feature macro: DR_ILLEGAL_CHECK_EN (illegal-codeword detection).
module dual_rail_shift_pipe
  import pa_AsyncCordic::*;
#(
  parameter int unsigned SIZE        = RW,
  parameter int unsigned SHIFT_W     = 4,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  dual_rail_shift_pipe_if.slave bus,
  output logic                  err_illegal
);

  localparam int unsigned LVLS = SHIFT_W / PIPE_STAGES;
  localparam int unsigned LAST = PIPE_STAGES - 1;

  typedef dual_rail_t [SIZE:0] word_t;

  word_t              data_q  [PIPE_STAGES];
  logic [SHIFT_W-1:0] shamt_q [PIPE_STAGES];
  shift_mode_t        mode_q  [PIPE_STAGES];
  word_t              stage_d [PIPE_STAGES];
  logic [LAST:0]      valid_q;
  logic [LAST:0]      ld;

  in_state_t state_q, state_d;
  logic      ack_q, ack_d;
  logic      accept;
  logic      in_complete, in_null;

  always_comb begin
    in_complete = 1'b1;
    in_null     = 1'b1;
    for (int unsigned i = 0; i <= SIZE; i++) begin
      in_complete = in_complete && dr_complete(bus.in_data[i]);
      in_null     = in_null && dr_null(bus.in_data[i]);
    end
  end

  // A stage may load when it is empty or anything downstream of it moves,
  // so bubbles close up while the output is stalled.
  always_comb begin
    logic go;
    go = bus.out_ready;
    ld = '0;
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      go = go || !valid_q[LAST - k];
      ld[LAST - k] = go;
    end
  end

`ifdef DR_ILLEGAL_CHECK_EN
  logic in_illegal;
  logic err_set;
  logic err_q;

  always_comb begin
    in_illegal = 1'b0;
    for (int unsigned i = 0; i <= SIZE; i++)
      in_illegal = in_illegal || dr_illegal(bus.in_data[i]);
  end
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    accept  = 1'b0;
`ifdef DR_ILLEGAL_CHECK_EN
    err_set = 1'b0;
`endif
    case (state_q)
      IN_WAIT_DATA: begin
`ifdef DR_ILLEGAL_CHECK_EN
        // Illegal word is consumed without acknowledge; resume after its NULL.
        if (in_illegal) begin
          err_set = 1'b1;
          state_d = IN_WAIT_NULL;
        end else
`endif
        if (in_complete && ld[0]) begin
          accept  = 1'b1;
          ack_d   = 1'b1;
          state_d = IN_WAIT_NULL;
        end
      end
      IN_WAIT_NULL: begin
        if (in_null) begin
          ack_d   = 1'b0;
          state_d = IN_WAIT_DATA;
        end
      end
      default: state_d = IN_WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IN_WAIT_DATA;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

`ifdef DR_ILLEGAL_CHECK_EN
  always_ff @(posedge clk) begin
    if (arst)         err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign err_illegal = err_q;
`else
  assign err_illegal = 1'b0;
`endif

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    word_t            src;
    logic [LVLS-1:0]  src_en;
    shift_mode_t      src_mode;
    word_t            lvl [LVLS+1];

    if (s == 0) begin : g_in
      assign src      = bus.in_data;
      assign src_en   = bus.in_shamt[0 +: LVLS];
      assign src_mode = bus.in_mode;
    end else begin : g_reg
      assign src      = data_q[s-1];
      assign src_en   = shamt_q[s-1][s*LVLS +: LVLS];
      assign src_mode = mode_q[s-1];
    end

    assign lvl[0] = src;

    for (genvar j = 0; j < LVLS; j++) begin : g_lvl
      dual_rail_t fill;
      // ASR keeps the sign in the MSB at every level, so the current MSB
      // is always the original sign rail pair.
      assign fill = (src_mode == SH_ASR) ? lvl[j][SIZE] : DR_ZERO;

      dual_rail_shift_level #(
        .SIZE  (SIZE),
        .SHIFT (2 ** (s * LVLS + j))
      ) u_level (
        .din  (lvl[j]),
        .en   (src_en[j]),
        .mode (src_mode),
        .fill (fill),
        .dout (lvl[j+1])
      );
    end

    assign stage_d[s] = lvl[LVLS];
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      valid_q <= '0;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        mode_q[s]  <= SH_LSL;
      end
    end else begin
      if (ld[0]) begin
        valid_q[0] <= accept;
        data_q[0]  <= stage_d[0];
        shamt_q[0] <= bus.in_shamt;
        mode_q[0]  <= bus.in_mode;
      end
      for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
        if (ld[s]) begin
          valid_q[s] <= valid_q[s-1];
          data_q[s]  <= stage_d[s];
          shamt_q[s] <= shamt_q[s-1];
          mode_q[s]  <= mode_q[s-1];
        end
      end
    end
  end

  assign bus.in_ack    = ack_q;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_data  = valid_q[LAST] ? data_q[LAST] : '0;

endmodule
